core2apb_bridge: RTL and testbench
==================================

# core2apb_bridge

Converts the core's peripheral data port (req/gnt/rvalid protocol) into single APB3 transfers and drives the APB slave port of the peripheral bus wrapper, which decodes them to UART, GPIO, SPI, timer, GPDMA and the other peripherals. It issues one outstanding transfer at a time and tracks the APB access phase with a timeout counter. A peripheral that never asserts PREADY completes with an error response instead of hanging the core.

## Interface
- APB_ADDR_WIDTH, 32, address width on both sides
- APB_DATA_WIDTH, 32, data width on both sides
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; 0 disables the timeout
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- data_req_i  in  1  core request
- data_gnt_o  out  1  request accepted
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables; captured and ignored, since APB3 has no strobes
- data_addr_i  in  APB_ADDR_WIDTH  byte address
- data_wdata_i  in  APB_DATA_WIDTH  write data
- data_rvalid_o  out  1  response valid, one cycle per granted request
- data_rdata_o  out  APB_DATA_WIDTH  read data
- data_err_o  out  1  PSLVERR or timeout
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- pwrite_o  out  1  APB direction
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- FSM states and transitions:
  - IDLE: on data_req_i, go to SETUP.
  - SETUP: go to ACCESS after exactly one cycle.
  - ACCESS: on pready_i, go to RESP. On timeout, go to RESP.
  - RESP: go to IDLE after one cycle.
- data_gnt_o = data_req_i && state==IDLE (combinational). The request fields are registered on the grant edge.
- SETUP drives psel_o=1 and penable_o=0. ACCESS drives psel_o=1 and penable_o=1.
- paddr_o, pwrite_o and pwdata_o come from the captured registers. They are stable from SETUP through the end of ACCESS.
- On pready_i in ACCESS:
  - capture prdata_i; the captured value is 0 for writes;
  - capture pslverr_i into the error flag.
- Timeout:
  - An ACCESS-cycle counter clears on entry to SETUP and increments on each ACCESS cycle without pready_i.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates at its maximum; it never wraps.
  - When the counter equals TIMEOUT_CYCLES-1 and pready_i is low, the transfer aborts. The bridge exits ACCESS, deasserts psel_o and penable_o the next cycle, and sets the error flag with rdata = ERR_RDATA.
- pready_i in the same cycle as the timeout condition: pready_i wins and the response is normal.
- RESP drives data_rvalid_o=1 with the captured rdata and error flag. In all other states data_rvalid_o=0, data_rdata_o=0 and data_err_o=0.
- data_req_i held high through the transfer is not granted again until the FSM is back in IDLE.
- Reset asserted at any point:
  - all state, counter and capture registers clear immediately;
  - an in-flight transfer is dropped with no rvalid.

## Timing
- Reset values: data_gnt_o=0 (state forced to IDLE), data_rvalid_o=0, data_rdata_o=0, data_err_o=0, paddr_o=0, pwdata_o=0, pwrite_o=0, psel_o=0, penable_o=0.
- Zero-wait slave: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 (pready), rvalid in cycle 3. Latency is 3 cycles.
- Each wait state adds one cycle.
- Back-to-back throughput is 1 transfer per 4 cycles, because the next grant comes in the cycle after RESP.
- Timeout response: rvalid arrives TIMEOUT_CYCLES+2 cycles after the grant.

## Structure
- Package core2apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the ERR_RDATA default;
  - a function for the counter width.
- Sub-module apb_timeout_cnt holds the clear/enable/saturating counter with a `expired_o` output. It is tied off when TIMEOUT_CYCLES=0.
- The APB outputs map one-to-one onto the APB_BUS interface at the SoC level.

## Test plan
- Reset with rst_i pulsed mid-ACCESS -> all outputs are 0 asynchronously; no rvalid follows.
- Write to 0x1A10_0000 with data 0x1234_5678 and zero-wait slave -> gnt in cycle 0, psel in cycles 1-2, penable in cycle 2, paddr/pwdata stable in both, rvalid=1 with err=0 in cycle 3.
- Read from 0x1A10_1004 with 3 wait states and prdata 0xCAFE_0001 -> rvalid in cycle 6 with rdata=0xCAFE_0001 and err=0.
- Read with pslverr_i=1 on the ready cycle -> rvalid with err=1 and rdata equal to prdata_i.
- TIMEOUT_CYCLES=8 and pready_i held low -> psel drops after 8 ACCESS cycles, rvalid in cycle 10 with err=1 and rdata=0xDEAD_BEEF.
- pready_i asserted exactly on the timeout cycle, plus data_req_i held high continuously -> normal response; second grant appears only in the cycle after RESP.

Source files
------------

// File: rtl/core2apb_pkg.sv
// core2apb_pkg: shared types and helpers for the core-to-APB3 bridge
package core2apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating ACCESS-phase cycle counter flagging the last allowed cycle
module apb_timeout_cnt
    import core2apb_pkg::*;
#(
    parameter int LIMIT = 255
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr_i)
            cnt <= '0;
        else if (inc_i && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    assign expired_o = cnt == LAST;

endmodule

// File: rtl/core2apb_bridge.sv
// core2apb_bridge: core req/gnt/rvalid data port to single APB3 transfers with an access timeout
module core2apb_bridge
    import core2apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
)(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    state_e                    state, state_nxt;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                      we_q, err_q, expired, timeout;
    logic [3:0]                be_unused;

    // reset gating keeps the grant low even if the core holds req through reset
    assign data_gnt_o = data_req_i && state == IDLE && !rst_i;
    assign timeout    = state == ACCESS && !pready_i && expired;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .clr_i     (data_gnt_o),
                .inc_i     (state == ACCESS && !pready_i),
                .expired_o (expired)
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE)   ? (data_req_i ? SETUP : IDLE) :
                    (state == SETUP)  ? ACCESS :
                    (state == ACCESS) ? ((pready_i || expired) ? RESP : ACCESS) :
                                        IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_unused <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (data_gnt_o) begin
                addr_q    <= data_addr_i;
                wdata_q   <= data_wdata_i;
                we_q      <= data_we_i;
                be_unused <= data_be_i;
            end
            if (state == ACCESS && pready_i) begin
                rdata_q <= we_q ? '0 : prdata_i;
                err_q   <= pslverr_i;
            end else if (timeout) begin
                rdata_q <= ERR_RDATA;
                err_q   <= 1'b1;
            end
        end
    end

    assign paddr_o       = addr_q;
    assign pwdata_o      = wdata_q;
    assign pwrite_o      = we_q;
    assign psel_o        = state == SETUP || state == ACCESS;
    assign penable_o     = state == ACCESS;
    assign data_rvalid_o = state == RESP;
    assign data_rdata_o  = (state == RESP) ? rdata_q : '0;
    assign data_err_o    = state == RESP && err_q;

endmodule

// File: tb/tb_core2apb_bridge.sv
// tb_core2apb_bridge: randomized transfers against a cycle-count reference model of the bridge
module tb_core2apb_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, pready = 1'b0, pslverr = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0, prdata = '0;
    logic        gnt, rvalid, err, pwrite, psel, penable;
    logic [31:0] rdata, paddr, pwdata;
    int          checks = 0, errors = 0;

    core2apb_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
        .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_pwrite"}, pwrite, 0);
        check({tag, "_psel"}, psel, 0);
        check({tag, "_penable"}, penable, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req = 0; pready = 0;
            @(negedge clk);
            check("idle_rvalid", rvalid, 0);
            check("idle_psel", psel, 0);
        end
    endtask

    // Reference: a slave that waits `waits` ACCESS cycles before pready; waits >= T never answers in time
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] prd, input logic slv, input logic hold);
        int          resp;
        logic [31:0] exp_rd;
        logic        exp_err;
        if (waits >= T) begin
            resp = T + 2; exp_rd = 32'hDEAD_BEEF; exp_err = 1;
        end else begin
            resp = 3 + waits; exp_rd = w ? 32'h0 : prd; exp_err = slv;
        end
        @(posedge clk); #1;
        req = 1; we = w; addr = a; wdata = wd; be = 4'($urandom); pready = 0;
        @(negedge clk);
        check("gnt", gnt, 1);
        check("rvalid_c0", rvalid, 0);
        for (int k = 1; k <= resp; k++) begin
            @(posedge clk); #1;
            if (!hold) req = 0;
            we = 1'($urandom); addr = $urandom; wdata = $urandom;
            pready  = k >= 2 && k < resp && k - 2 == waits;
            prdata  = pready ? prd : $urandom;
            pslverr = pready ? slv : 1'($urandom);
            @(negedge clk);
            check("gnt_busy", gnt, 0);
            if (k < resp) begin
                check("psel", psel, 1);
                check("penable", penable, k >= 2);
                check("paddr", paddr, a);
                check("pwdata", pwdata, wd);
                check("pwrite", pwrite, w);
                check("rvalid_busy", rvalid, 0);
                check("rdata_busy", rdata, 0);
                check("err_busy", err, 0);
            end else begin
                check("rvalid", rvalid, 1);
                check("rdata", rdata, exp_rd);
                check("err", err, exp_err);
                check("psel_resp", psel, 0);
                check("penable_resp", penable, 0);
            end
        end
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        idle(2);

        xfer(1, 32'h1A10_0000, 32'h1234_5678, 0, 32'h0, 0, 0);
        xfer(0, 32'h1A10_1004, 32'h0, 3, 32'hCAFE_0001, 0, 0);
        xfer(0, 32'h1A10_2000, 32'h0, 1, 32'h5555_AAAA, 1, 0);
        xfer(0, 32'h1A10_3000, 32'h0, 1000, 32'h0, 0, 0);
        idle(1);
        xfer(0, 32'h1A10_4008, 32'h0, T - 1, 32'h0BAD_F00D, 0, 1);
        xfer(1, 32'h1A10_400C, 32'hFEED_0001, 0, 32'h0, 0, 1);
        idle(1);

        // reset in the middle of ACCESS: everything clears without waiting for a clock
        @(posedge clk); #1;
        req = 1; we = 1; addr = 32'h1A10_5000; wdata = 32'h7777_0000;
        repeat (3) @(posedge clk);
        #2;
        rst = 1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        req = 0;
        @(posedge clk); #1;
        rst = 0;
        idle(4);

        for (int i = 0; i < 40; i++) begin
            int w;
            w = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, T));
            xfer(1'($urandom), $urandom, $urandom, w, $urandom, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
